// File: rtl/divby_tick_monitor.sv
// Receive-side checker for divide-by-N tick streams: measures tick-to-tick
// period, declares lock after LOCK_CNT matching periods, flags loss of lock.
module divby_tick_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_DIV  = 3,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             clear_err,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] EXP  = CNT_W'(EXP_DIV);
    localparam logic [3:0]       LOCK = 4'(LOCK_CNT);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       match_cnt, match_cnt_d;
    logic             cnt_sat, match, measure, err_set;

    // A saturated count is an out-of-range gap and must never count as a match.
    assign cnt_sat = (cnt == '1);
    assign match   = tick_in && !cnt_sat && (cnt == EXP);

    always_comb begin
        state_d     = state;
        match_cnt_d = match_cnt;
        measure     = 1'b0;
        err_set     = 1'b0;
        case (state)
            IDLE: begin
                if (tick_in) begin
                    state_d     = MEASURE;
                    match_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (tick_in) begin
                    measure = 1'b1;
                    if (match) begin
                        match_cnt_d = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == LOCK)
                            state_d = LOCKED;
                    end else begin
                        match_cnt_d = '0;
                    end
                end else if (cnt_sat) begin
                    state_d     = IDLE;
                    match_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (tick_in) begin
                    measure = 1'b1;
                    if (!match) begin
                        state_d     = MEASURE;
                        match_cnt_d = '0;
                        err_set     = 1'b1;
                    end
                end else if (cnt_sat) begin
                    state_d     = IDLE;
                    match_cnt_d = '0;
                    err_set     = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                match_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            match_cnt    <= match_cnt_d;
            if (tick_in)
                cnt <= CNT_W'(1);
            else if (!cnt_sat)
                cnt <= cnt + CNT_W'(1);
            period_valid <= measure;
            if (measure)
                period <= cnt;
            locked       <= (state_d == LOCKED);
            // Set has priority over a simultaneous clear.
            err          <= err_set | (err & ~clear_err);
        end
    end

endmodule

// File: tb/tb_divby_tick_monitor.sv
// Randomized bench for divby_tick_monitor against a tick-timestamp reference model.
module tb_divby_tick_monitor;

    localparam int EXP_DIV  = 3;
    localparam int LOCK_CNT = 4;
    localparam int SAT      = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] period;
    logic       period_valid, locked, err;

    divby_tick_monitor #(.CNT_W(8), .EXP_DIV(EXP_DIV), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .clear_err(clear_err),
        .period(period), .period_valid(period_valid), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: timestamps of ticks, a run length of matching gaps.
    int cyc = 0;
    int last_t = 0;
    bit armed = 0;
    int run = 0;
    bit m_locked = 0, m_err = 0, m_pv = 0;
    int m_period = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model(input bit t, input bit clr, input bit rst);
        int  diff;
        int  gap;
        bit  set_e;
        set_e = 0;
        m_pv  = 0;
        diff  = cyc - last_t;
        gap   = (diff > SAT) ? SAT : diff;
        if (rst) begin
            armed = 0; run = 0; m_locked = 0; m_err = 0; m_period = 0;
        end else begin
            if (t) begin
                if (armed) begin
                    m_pv = 1;
                    m_period = gap;
                    if (gap == EXP_DIV) begin
                        run++;
                        if (!m_locked && run == LOCK_CNT) m_locked = 1;
                    end else begin
                        if (m_locked) set_e = 1;
                        m_locked = 0;
                        run = 0;
                    end
                end else begin
                    armed = 1;
                    run = 0;
                end
                last_t = cyc;
            end else if (armed && diff >= SAT) begin
                armed = 0;
                if (m_locked) set_e = 1;
                m_locked = 0;
                run = 0;
            end
            if (set_e) m_err = 1;
            else if (clr) m_err = 0;
        end
    endtask

    task automatic step(input bit t, input bit clr, input bit rst);
        @(negedge clk);
        tick_in = t;
        clear_err = clr;
        reset = rst;
        model(t, clr, rst);
        @(posedge clk);
        #1;
        check("period_valid", int'(period_valid), int'(m_pv));
        check("period", int'(period), m_period);
        check("locked", int'(locked), int'(m_locked));
        check("err", int'(err), int'(m_err));
        cyc++;
    endtask

    // One tick (optionally with clear_err) followed by n-1 quiet cycles.
    task automatic gap(input int n, input bit clr);
        step(1, clr, 0);
        for (int i = 1; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        step(0, 0, 1);
        step(0, 0, 1);
        // Lock on a clean divide-by-3 stream.
        for (int i = 0; i < 6; i++) gap(3, 0);
        // Late tick breaks lock, then relock.
        gap(5, 0);
        for (int i = 0; i < 6; i++) gap(3, 0);
        // Timeout while locked.
        gap(300, 0);
        for (int i = 0; i < 3; i++) gap(3, 0);
        step(0, 1, 0);
        // Tick held high.
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        step(0, 0, 0);
        // Lock loss coincident with clear_err, then a plain clear.
        for (int i = 0; i < 6; i++) gap(3, 0);
        gap(5, 0);
        gap(3, 1);
        step(0, 1, 0);
        step(0, 0, 0);
        // Reset mid-lock, then relock from scratch.
        for (int i = 0; i < 6; i++) gap(3, 0);
        step(0, 0, 1);
        for (int i = 0; i < 6; i++) gap(3, 0);
        // Randomized gaps, clears and resets.
        for (int k = 0; k < 250; k++) begin
            int r;
            int n;
            r = int'($urandom_range(0, 99));
            if (r < 65)      n = EXP_DIV;
            else if (r < 88) n = int'($urandom_range(1, 6));
            else if (r < 92) n = int'($urandom_range(250, 300));
            else if (r < 95) begin
                step(0, 0, 1);
                n = 0;
            end else begin
                step(0, 1, 0);
                n = 0;
            end
            if (n > 0) gap(n, $urandom_range(0, 9) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
